// File: rtl/beta_muldiv_pkg.sv
// Shared encodings and helpers for the Beta iterative multiply/divide unit.
// Operation codes, controller states and a two's-complement magnitude function.
package beta_muldiv_pkg;

    localparam int MAG_W = 64;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } state_e;

    // Callers zero-extend a narrower value to MAG_W and truncate the result back.
    function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W-1:0] value,
                                                   input logic negative);
        return negative ? -value : value;
    endfunction

endpackage

// File: rtl/beta_muldiv_divstep.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module beta_divstep
    import beta_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/beta_muldiv.sv
// Iterative signed multiply/divide unit, one bit per cycle on operand magnitudes,
// with sign correction in a final FIXUP cycle and a start/busy/done handshake.
module beta_muldiv
    import beta_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_res_q, neg_res_d;
    logic                 dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [WIDTH-1:0]     acc_hi, acc_lo;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     div_rem, div_quo;
    logic [2*WIDTH-1:0]   signed_prod;
    logic [WIDTH-1:0]     fixup_result;

    assign mag_a_in = WIDTH'(magnitude(MAG_W'(a), a[WIDTH-1]));
    assign mag_b_in = WIDTH'(magnitude(MAG_W'(b), b[WIDTH-1]));

    // The accumulator holds {partial product, multiplier} or {remainder, quotient}.
    assign acc_hi  = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo  = acc_q[WIDTH-1:0];
    assign mul_sum = {1'b0, acc_hi} + {1'b0, mag_b_q};

    beta_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i     (acc_hi),
        .quo_i     (acc_lo),
        .divisor_i (mag_b_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    assign signed_prod = neg_res_q ? -acc_q : acc_q;

    always_comb begin
        fixup_result = '0;
        case (op_q)
            OP_MUL:  fixup_result = signed_prod[WIDTH-1:0];
            OP_MULH: fixup_result = signed_prod[2*WIDTH-1:WIDTH];
            OP_DIV:  fixup_result = dz_pend_q ? '1 : (neg_res_q ? -acc_lo : acc_lo);
            OP_REM:  fixup_result = dz_pend_q ? (neg_a_q ? -acc_lo : acc_lo)
                                              : (neg_a_q ? -acc_hi : acc_hi);
            default: fixup_result = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_a_d    = neg_a_q;
        neg_res_d  = neg_res_q;
        dz_pend_d  = dz_pend_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d      = op_e'(op);
                    neg_a_d   = a[WIDTH-1];
                    neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
                    dz_pend_d = op[1] && (b == '0);
                    mag_b_d   = mag_b_in;
                    acc_d     = {{WIDTH{1'b0}}, mag_a_in};
                    count_d   = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = (op[1] && (b == '0)) ? FIXUP : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (op_q[1]) begin
                        acc_d = {div_rem, div_quo};
                    end else if (acc_lo[0]) begin
                        acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!flush) begin
                    result_d   = fixup_result;
                    div_zero_d = dz_pend_q;
                    done_d     = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            neg_a_q    <= 1'b0;
            neg_res_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            neg_a_q    <= neg_a_d;
            neg_res_q  <= neg_res_d;
            dz_pend_q  <= dz_pend_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule
